// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle MIPS control unit.
// Runs one instruction at a time through a Moore FSM. Memory states are
// stretched by the mem_ready handshake. Also counts retired instructions.
// Ports:
//   clk, reset (sync, active-high)
//   opcode (IR[31:26]), zero (ALU flag), mem_ready (memory handshake)
//   pc_load, ir_we, mdr_we, ab_we, aluout_we, rf_we : register write enables
//   mem_rd, mem_wr : memory strobes
//   iord, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src : datapath selects
//   instr_done : pulse on the last cycle of an instruction
//   illegal    : pulse in DECODE on an unsupported opcode
//   state      : current state, for debug
//   retired    : completed-instruction count
module mc_ctrl_fsm (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_load,
  output logic        ir_we,
  output logic        mdr_we,
  output logic        ab_we,
  output logic        aluout_we,
  output logic        rf_we,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        iord,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic [1:0]  pc_src,
  output logic        instr_done,
  output logic        illegal,
  output logic [3:0]  state,
  output logic [31:0] retired
);

  localparam int unsigned RetW = 32;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpAddi  = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [RetW-1:0] r_retired;

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  // Retired-instruction counter; wraps naturally at 2^32
  always_ff @(posedge clk) begin
    if (reset)           r_retired <= '0;
    else if (instr_done) r_retired <= r_retired + RetW'(1);
  end

  // Next-state and output decode
  always_comb begin
    w_next     = r_state;
    pc_load    = 1'b0;
    ir_we      = 1'b0;
    mdr_we     = 1'b0;
    ab_we      = 1'b0;
    aluout_we  = 1'b0;
    rf_we      = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    iord       = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_src     = 2'b00;
    instr_done = 1'b0;
    illegal    = 1'b0;

    case (r_state)
      S_FETCH: begin
        mem_rd    = 1'b1;
        alu_src_b = 2'b01;
        ir_we     = mem_ready;
        pc_load   = mem_ready;
        if (mem_ready) w_next = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        ab_we     = 1'b1;
        aluout_we = 1'b1;
        case (opcode)
          OpLw, OpSw: w_next = S_MEMADR;
          OpRtype:    w_next = S_EXEC;
          OpBeq:      w_next = S_BRANCH;
          OpJ:        w_next = S_JUMP;
          OpAddi:     w_next = S_ADDIEX;
          default: begin
            illegal = 1'b1;
            w_next  = S_FETCH;
          end
        endcase
      end
      S_MEMADR, S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        aluout_we = 1'b1;
        if (r_state == S_ADDIEX) w_next = S_ADDIWB;
        else if (opcode == OpSw) w_next = S_MEMWR;
        else                     w_next = S_MEMRD;
      end
      S_MEMRD: begin
        iord   = 1'b1;
        mem_rd = 1'b1;
        mdr_we = mem_ready;
        if (mem_ready) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        rf_we      = 1'b1;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end
      S_MEMWR: begin
        iord       = 1'b1;
        mem_wr     = 1'b1;
        instr_done = mem_ready;
        if (mem_ready) w_next = S_FETCH;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        aluout_we = 1'b1;
        w_next    = S_RWB;
      end
      S_RWB: begin
        reg_dst    = 1'b1;
        rf_we      = 1'b1;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end
      S_ADDIWB: begin
        rf_we      = 1'b1;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = 2'b01;
        pc_src     = 2'b01;
        pc_load    = zero;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end
      S_JUMP: begin
        pc_src     = 2'b10;
        pc_load    = 1'b1;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end
      // Unused codes 12-15 recover to FETCH
      default: w_next = S_FETCH;
    endcase
  end

  assign state   = 4'(r_state);
  assign retired = r_retired;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: directed self-checking bench for mc_ctrl_fsm.
// Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later.
module tb_mc_ctrl_fsm;

  logic        clk;
  logic        reset;
  logic [5:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic        pc_load, ir_we, mdr_we, ab_we, aluout_we, rf_we;
  logic        mem_rd, mem_wr, iord, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0]  alu_src_b, alu_op, pc_src;
  logic        instr_done, illegal;
  logic [3:0]  state;
  logic [31:0] retired;

  int n_checks = 0;
  int n_fail   = 0;

  mc_ctrl_fsm dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_load    (pc_load),
    .ir_we      (ir_we),
    .mdr_we     (mdr_we),
    .ab_we      (ab_we),
    .aluout_we  (aluout_we),
    .rf_we      (rf_we),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .iord       (iord),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .pc_src     (pc_src),
    .instr_done (instr_done),
    .illegal    (illegal),
    .state      (state),
    .retired    (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after an input change
  task automatic settle();
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    opcode    = 6'b000000;
    zero      = 1'b0;
    mem_ready = 1'b0;
    tick();
    tick();
    settle();
    // Reset: FETCH decode only
    check("rst_state",   32'(state),     32'd0);
    check("rst_retired", retired,        32'd0);
    check("rst_mem_rd",  32'(mem_rd),    32'd1);
    check("rst_srcb",    32'(alu_src_b), 32'd1);
    check("rst_ir_we",   32'(ir_we),     32'd0);
    check("rst_pc_load", 32'(pc_load),   32'd0);
    check("rst_done",    32'(instr_done),32'd0);

    // R-type: 0,1,6,7,0
    reset = 1'b0; mem_ready = 1'b1; opcode = 6'b000000;
    settle();
    check("r_s0",     32'(state),   32'd0);
    check("r_ir_we",  32'(ir_we),   32'd1);
    check("r_pcload", 32'(pc_load), 32'd1);
    tick(); settle();
    check("r_s1",     32'(state),     32'd1);
    check("r_ab_we",  32'(ab_we),     32'd1);
    check("r_srcb11", 32'(alu_src_b), 32'd3);
    tick(); settle();
    check("r_s6",     32'(state),  32'd6);
    check("r_aluop",  32'(alu_op), 32'd2);
    tick(); settle();
    check("r_s7",     32'(state),      32'd7);
    check("r_rf_we",  32'(rf_we),      32'd1);
    check("r_regdst", 32'(reg_dst),    32'd1);
    check("r_done",   32'(instr_done), 32'd1);
    tick(); settle();
    check("r_end_s0", 32'(state), 32'd0);
    check("r_ret",    retired,    32'd1);

    // lw with two MEMRD wait cycles: 0,1,2,3,3,3,4,0
    opcode = 6'b100011; mem_ready = 1'b1;
    settle();
    check("lw_s0", 32'(state), 32'd0);
    tick(); settle();
    check("lw_s1", 32'(state), 32'd1);
    tick(); settle();
    check("lw_s2",    32'(state),     32'd2);
    check("lw_srca",  32'(alu_src_a), 32'd1);
    check("lw_srcb",  32'(alu_src_b), 32'd2);
    tick(); mem_ready = 1'b0; settle();
    check("lw_s3a",    32'(state),  32'd3);
    check("lw_mdr_a",  32'(mdr_we), 32'd0);
    check("lw_rd_a",   32'(mem_rd), 32'd1);
    check("lw_iord_a", 32'(iord),   32'd1);
    check("lw_abwe_a", 32'(ab_we),  32'd0);
    tick(); settle();
    check("lw_s3b",   32'(state),  32'd3);
    check("lw_mdr_b", 32'(mdr_we), 32'd0);
    tick(); mem_ready = 1'b1; settle();
    check("lw_s3c",   32'(state),  32'd3);
    check("lw_mdr_c", 32'(mdr_we), 32'd1);
    tick(); settle();
    check("lw_s4",     32'(state),      32'd4);
    check("lw_m2r",    32'(mem_to_reg), 32'd1);
    check("lw_rf_we",  32'(rf_we),      32'd1);
    check("lw_done",   32'(instr_done), 32'd1);
    tick(); settle();
    check("lw_end_s0", 32'(state), 32'd0);
    check("lw_ret",    retired,    32'd2);

    // beq taken then not taken
    opcode = 6'b000100; zero = 1'b1;
    tick(); tick(); settle();
    check("beq1_s8",    32'(state),   32'd8);
    check("beq1_pcld",  32'(pc_load), 32'd1);
    check("beq1_pcsrc", 32'(pc_src),  32'd1);
    check("beq1_aluop", 32'(alu_op),  32'd1);
    tick(); zero = 1'b0; settle();
    check("beq2_s0", 32'(state), 32'd0);
    tick(); tick(); settle();
    check("beq2_s8",    32'(state),   32'd8);
    check("beq2_pcld",  32'(pc_load), 32'd0);
    check("beq2_pcsrc", 32'(pc_src),  32'd1);
    tick(); settle();
    check("beq_ret", retired, 32'd4);

    // Illegal opcode
    opcode = 6'b111111;
    tick(); settle();
    check("ill_s1",   32'(state),      32'd1);
    check("ill_flag", 32'(illegal),    32'd1);
    check("ill_done", 32'(instr_done), 32'd0);
    tick(); settle();
    check("ill_s0",    32'(state),   32'd0);
    check("ill_clear", 32'(illegal), 32'd0);
    check("ill_ret",   retired,      32'd4);

    // addi: 0,1,10,11,0
    opcode = 6'b001000;
    tick(); tick(); settle();
    check("addi_s10",  32'(state),     32'd10);
    check("addi_srcb", 32'(alu_src_b), 32'd2);
    tick(); settle();
    check("addi_s11",    32'(state),   32'd11);
    check("addi_rf_we",  32'(rf_we),   32'd1);
    check("addi_regdst", 32'(reg_dst), 32'd0);
    tick(); settle();
    check("addi_ret", retired, 32'd5);

    // sw with one MEMWR wait, then reset in MEMWR
    opcode = 6'b101011;
    tick(); tick(); settle();
    check("sw_s2", 32'(state), 32'd2);
    tick(); mem_ready = 1'b0; settle();
    check("sw_s5",     32'(state),      32'd5);
    check("sw_wr",     32'(mem_wr),     32'd1);
    check("sw_done_w", 32'(instr_done), 32'd0);
    tick(); mem_ready = 1'b1; reset = 1'b1; settle();
    check("sw_s5_hold", 32'(state),      32'd5);
    check("sw_done",    32'(instr_done), 32'd1);
    tick(); reset = 1'b0; mem_ready = 1'b0; settle();
    check("swr_s0",   32'(state),   32'd0);
    check("swr_ret",  retired,      32'd0);
    check("swr_wr",   32'(mem_wr),  32'd0);
    check("swr_rd",   32'(mem_rd),  32'd1);
    check("swr_pcld", 32'(pc_load), 32'd0);

    // Counter wrap on j, with a FETCH wait cycle
    force dut.r_retired = 32'hFFFF_FFFF;
    #1;
    release dut.r_retired;
    opcode = 6'b000010;
    settle();
    check("j_preload", retired, 32'hFFFF_FFFF);
    check("j_fwait_ir", 32'(ir_we), 32'd0);
    tick(); mem_ready = 1'b1; settle();
    check("j_fwait_s0", 32'(state), 32'd0);
    tick(); tick(); settle();
    check("j_s9",    32'(state),   32'd9);
    check("j_pcld",  32'(pc_load), 32'd1);
    check("j_pcsrc", 32'(pc_src),  32'd2);
    tick(); settle();
    check("j_s0",   32'(state), 32'd0);
    check("j_wrap", retired,    32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
